matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
Sequencer for the NxN matrix-multiply datapath: A/B operand memories, one shared multiply-accumulate unit, and the 16-bit result memory R.
- Walks i/j/k loops and issues A/B read addresses.
- Tags the MAC pipeline with first/last markers.
- Generates R write strobes and addresses.
- Sits between the UART receive/transmit FSM (start/done handshake) and the datapath, replacing inline loop logic.

Parameters:
MAX_SIZE, 10, largest accepted N
ADDR_W, 7, element address width (≥ clog2(MAX_SIZE*MAX_SIZE))
MEM_LAT, 1, A/B read latency in cycles (rd_en to data valid); legal 1..3

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request a multiply; sampled only in IDLE
size  in  8  N, sampled with start
stall  in  1  freeze operand issue (R/transmit port contention)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse, job complete
err  out  1  one-cycle pulse, start with illegal size
rd_en  out  1  A/B read strobe
a_addr  out  ADDR_W  i*N+k
b_addr  out  ADDR_W  k*N+j
mac_valid  out  1  operand pair valid at MAC input
mac_first  out  1  with mac_valid: load product (k==0)
mac_last  out  1  with mac_valid: final term (k==N-1)
r_we  out  1  write accumulator to R
r_addr  out  ADDR_W  i*N+j for r_we
cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; counters 0. Reset mid-job aborts the job with no done pulse; in-flight markers are discarded.
- States:
  - IDLE: on start with 2≤size≤MAX_SIZE, latch N, clear i/j/k, go to ISSUE. On start with an illegal size, pulse err next cycle and stay in IDLE.
  - ISSUE: each non-stalled cycle, rd_en=1 with the current addresses, then advance k→j→i (k fastest). After issuing (N-1,N-1,N-1), go to DRAIN.
  - DRAIN: wait for the pipeline to empty. After the last r_we, go to DONE.
  - DONE: pulse done for one cycle, drop busy, return to IDLE.
- Stall: while stall=1 in ISSUE, rd_en=0 and the indices hold. In-flight operations still drain. Stall is ignored in the other states.
- Pipeline: mac_valid, mac_first and mac_last are rd_en, (k==0) and (k==N-1) delayed MEM_LAT cycles. r_we = mac_valid&mac_last delayed 1 (MAC register stage). r_addr is aligned with r_we.
- Latency, no stall: start accepted at cycle 0; rd_en in cycles 1..N³; last r_we at N³+MEM_LAT+1; done at N³+MEM_LAT+2. Each stall cycle adds one.
- Addresses use incremental adders only (row bases i*N, k*N kept as registers); no multipliers. Width is ADDR_W; no wrap occurs for legal N.
- start while busy is ignored; no queuing.
- start in the same cycle as done is ignored (state is DONE, not IDLE).
- size is don't-care outside start.

Optional Feature:
Macro PERF_CNT_EN.
- Defined: cycles clears on start acceptance, increments every cycle busy=1 (stall cycles included), and holds after done until the next start.
- Undefined: cycles tied to 0 and no counter is synthesized.

Decomposition:
- Package matmul_pkg:
  - MAX_SIZE, ADDR_W, MAX_ELEMENTS defaults
  - state enum (IDLE, ISSUE, DRAIN, DONE)
  - pipeline tag struct (valid, first, last, r_addr)
- Sub-module matmul_idx_counter: nested i/j/k counter with base-address accumulators, enable and wrap flags. It is reused by the result-transmit sequencer for its row/column walk.

Test Plan:
- N=2, no stall, MEM_LAT=1 → 8 rd_en cycles. a_addr sequence 0,1,0,1,2,3,2,3; b_addr 0,2,1,3,0,2,1,3; r_we at addresses 0,1,2,3; done at cycle 11.
- N=3 → done exactly at cycle 30; 9 r_we pulses; mac_first/mac_last each asserted 9 times.
- size=1 and size=11 with start → err pulse, busy stays 0, no rd_en. Then size=10 → last r_addr 99, done at cycle 1003.
- N=2, stall held for 5 cycles after the third issue → addresses resume at (0,1,1) with no skipped or duplicated issue; done at cycle 16.
- rst_n low in ISSUE cycle 4 → all outputs 0 immediately, no done. A new start of N=2 afterwards completes normally.
- start pulsed during busy and in the done cycle → ignored, exactly one done. With PERF_CNT_EN, cycles=10 after an N=2 job.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the matrix-multiply sequencer.
// The counter file, the top level and the bench all import this package.
package matmul_pkg;

    localparam int MAX_SIZE     = 10;
    localparam int ADDR_W       = 7;
    localparam int MAX_ELEMENTS = MAX_SIZE * MAX_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Marker that travels alongside an operand read until it reaches the MAC.
    typedef struct packed {
        logic              valid;
        logic              first;
        logic              last;
        logic [ADDR_W-1:0] r_addr;
    } pipe_tag_t;

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested i/j/k walk (k fastest) with running row bases i*N and k*N, so the
// element addresses need only adders. The transmit sequencer reuses it for its row/column walk.
module matmul_idx_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] n,
    input  logic         en,
    output logic [W-1:0] a_addr,
    output logic [W-1:0] b_addr,
    output logic [W-1:0] r_addr,
    output logic         k_first,
    output logic         k_last,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] n_q, n_d;
    logic [W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [W-1:0] i_base_q, i_base_d, k_base_q, k_base_d;
    logic         j_last, i_last;

    assign k_first = (k_q == '0);
    assign k_last  = (k_q == n_q - ONE);
    assign j_last  = (j_q == n_q - ONE);
    assign i_last  = (i_q == n_q - ONE);
    assign wrap    = k_last & j_last & i_last;

    assign a_addr = i_base_q + k_q;
    assign b_addr = k_base_q + j_q;
    assign r_addr = i_base_q + j_q;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        n_d      = n_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        i_base_d = i_base_q;
        k_base_d = k_base_q;
        if (clear) begin
            n_d      = n;
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            i_base_d = '0;
            k_base_d = '0;
        end else if (en) begin
            if (!k_last) begin
                k_d      = k_q + ONE;
                k_base_d = k_base_q + n_q;
            end else begin
                k_d      = '0;
                k_base_d = '0;
                if (!j_last) begin
                    j_d = j_q + ONE;
                end else begin
                    j_d = '0;
                    if (!i_last) begin
                        i_d      = i_q + ONE;
                        i_base_d = i_base_q + n_q;
                    end else begin
                        i_d      = '0;
                        i_base_d = '0;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            i_base_q <= '0;
            k_base_q <= '0;
        end else begin
            n_q      <= n_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            i_base_q <= i_base_d;
            k_base_q <= k_base_d;
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer between the UART start/done handshake and the A/B/MAC/R datapath.
// Optional busy-cycle counter: define PERF_CNT_EN.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int MAX_SIZE = matmul_pkg::MAX_SIZE,
    parameter int ADDR_W   = matmul_pkg::ADDR_W,
    parameter int MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        size,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [31:0]       cycles
);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic              r_we_q, r_we_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    pipe_tag_t         pipe_q [MEM_LAT];
    pipe_tag_t         pipe_d [MEM_LAT];
    pipe_tag_t         mac_tag;

    logic              size_ok, start_ok, start_bad, pipe_busy;
    logic              k_first, k_last, wrap;
    logic [ADDR_W-1:0] idx_r_addr;

    assign size_ok   = (size >= 8'd2) && (size <= 8'(MAX_SIZE));
    assign start_ok  = (state_q == ST_IDLE) && start && size_ok;
    assign start_bad = (state_q == ST_IDLE) && start && !size_ok;

    assign rd_en = (state_q == ST_ISSUE) && !stall;
    assign busy  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done  = (state_q == ST_DONE);

    matmul_idx_counter #(.W(ADDR_W)) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok),
        .n       (size[ADDR_W-1:0]),
        .en      (rd_en),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .r_addr  (idx_r_addr),
        .k_first (k_first),
        .k_last  (k_last),
        .wrap    (wrap)
    );

    // Tags shift every cycle regardless of stall so in-flight reads drain.
    always_comb begin
        pipe_d[0] = '{valid: rd_en, first: rd_en & k_first,
                      last: rd_en & k_last, r_addr: idx_r_addr};
        for (int s = 1; s < MEM_LAT; s++) pipe_d[s] = pipe_q[s-1];
        pipe_busy = 1'b0;
        for (int s = 0; s < MEM_LAT; s++) pipe_busy |= pipe_q[s].valid;
    end

    assign mac_tag   = pipe_q[MEM_LAT-1];
    assign mac_valid = mac_tag.valid;
    assign mac_first = mac_tag.first;
    assign mac_last  = mac_tag.last;

    always_comb begin
        state_d  = state_q;
        err_d    = start_bad;
        r_we_d   = mac_tag.valid & mac_tag.last;
        r_addr_d = r_we_d ? mac_tag.r_addr : r_addr_q;
        unique case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_ISSUE;
            ST_ISSUE: if (rd_en && wrap) state_d = ST_DRAIN;
            // Exit on the write that leaves nothing behind it in the pipeline.
            ST_DRAIN: if (r_we_q && !pipe_busy) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            r_we_q   <= 1'b0;
            r_addr_q <= '0;
            // NOTE: the tag chain is a handful of flops, not a memory, so it is
            // reset; that is what discards in-flight markers on an abort.
            for (int s = 0; s < MEM_LAT; s++) pipe_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            r_we_q   <= r_we_d;
            r_addr_q <= r_addr_d;
            for (int s = 0; s < MEM_LAT; s++) pipe_q[s] <= pipe_d[s];
        end
    end

    assign err    = err_q;
    assign r_we   = r_we_q;
    assign r_addr = r_addr_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (start_ok)  cycles_d = '0;
        else if (busy) cycles_d = cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycles_q <= '0;
        else        cycles_q <= cycles_d;
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: scoreboard of expected issues and
// result writes, table of job sizes, plus stall/reset/ignored-start sequences.
module tb_matmul_seq_ctrl;

    localparam int AW = 7;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
    logic [7:0]    size = 8'd0;
    logic          busy, done, err, rd_en, mac_valid, mac_first, mac_last, r_we;
    logic [AW-1:0] a_addr, b_addr, r_addr;
    logic [31:0]   cycles;

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.MAX_SIZE(10), .ADDR_W(AW), .MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size), .stall(stall),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en),
        .a_addr(a_addr), .b_addr(b_addr), .mac_valid(mac_valid),
        .mac_first(mac_first), .mac_last(mac_last), .r_we(r_we),
        .r_addr(r_addr), .cycles(cycles)
    );

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } issue_t;

    issue_t        issue_q[$];
    logic [AW-1:0] raddr_q[$];
    int rd_cnt = 0, we_cnt = 0, first_cnt = 0, last_cnt = 0, done_cnt = 0;
    int last_raddr = 0;

    // Monitor: pops the scoreboard whenever the DUT issues or writes.
    always @(negedge clk) begin : monitor
        issue_t        e;
        logic [AW-1:0] ra;
        if (rst_n) begin
            if (rd_en) begin
                rd_cnt++;
                if (issue_q.size() == 0) check("unexpected_rd_en", 32'd1, 32'd0);
                else begin
                    e = issue_q.pop_front();
                    check("a_addr", 32'(a_addr), 32'(e.a));
                    check("b_addr", 32'(b_addr), 32'(e.b));
                end
            end
            if (r_we) begin
                we_cnt++;
                last_raddr = int'(r_addr);
                if (raddr_q.size() == 0) check("unexpected_r_we", 32'd1, 32'd0);
                else begin
                    ra = raddr_q.pop_front();
                    check("r_addr", 32'(r_addr), 32'(ra));
                end
            end
            if (mac_valid && mac_first) first_cnt++;
            if (mac_valid && mac_last)  last_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic push_model(input int n);
        issue_t e;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                for (int k = 0; k < n; k++) begin
                    e.a = AW'(i * n + k);
                    e.b = AW'(k * n + j);
                    issue_q.push_back(e);
                end
                raddr_q.push_back(AW'(i * n + j));
            end
    endtask

    // Drives start for one cycle; t0 is the cycle in which it is presented.
    task automatic start_job(input int n, input bit expect_ok, output int t0);
        if (expect_ok) push_model(n);
        @(posedge clk); #1;
        start = 1'b1;
        size  = 8'(n);
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        size  = 8'($urandom);
    endtask

    task automatic wait_done(input string name, input int t0, input int exp_lat);
        int got = 0, dc = 0;
        for (int c = 0; c < 3000 && got == 0; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                dc  = cyc;
                check({name, "_busy_at_done"}, 32'(busy), 32'd0);
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        if (got != 0) check({name, "_done_cycle"}, 32'(dc - t0), 32'(exp_lat));
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_issue_q_empty"}, 32'(issue_q.size()), 32'd0);
        check({name, "_raddr_q_empty"}, 32'(raddr_q.size()), 32'd0);
    endtask

    typedef struct {
        int size;
        bit bad;
        int lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t0, rd0, we0, f0, l0, d0;

        vecs[0] = '{size: 2,  bad: 1'b0, lat: 11};
        vecs[1] = '{size: 3,  bad: 1'b0, lat: 30};
        vecs[2] = '{size: 1,  bad: 1'b1, lat: 0};
        vecs[3] = '{size: 11, bad: 1'b1, lat: 0};
        vecs[4] = '{size: 0,  bad: 1'b1, lat: 0};
        vecs[5] = '{size: 10, bad: 1'b0, lat: 1003};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_r_we", 32'(r_we), 32'd0);
        check("rst_mac_valid", 32'(mac_valid), 32'd0);
        check("rst_addr", 32'({a_addr, b_addr, r_addr}), 32'd0);
        check("rst_cycles", cycles, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            rd0 = rd_cnt; we0 = we_cnt; f0 = first_cnt; l0 = last_cnt;
            start_job(vecs[v].size, !vecs[v].bad, t0);
            @(negedge clk);
            if (vecs[v].bad) begin
                check($sformatf("v%0d_err_pulse", v), 32'(err), 32'd1);
                check($sformatf("v%0d_bad_busy", v), 32'(busy), 32'd0);
                @(negedge clk);
                check($sformatf("v%0d_err_cleared", v), 32'(err), 32'd0);
                repeat (3) @(negedge clk);
                check($sformatf("v%0d_bad_no_rd", v), 32'(rd_cnt - rd0), 32'd0);
                check($sformatf("v%0d_bad_idle", v), 32'(busy), 32'd0);
            end else begin
                check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
                check($sformatf("v%0d_no_err", v), 32'(err), 32'd0);
                wait_done($sformatf("v%0d", v), t0, vecs[v].lat);
                check($sformatf("v%0d_rd_cnt", v), 32'(rd_cnt - rd0),
                      32'(vecs[v].size ** 3));
                check($sformatf("v%0d_we_cnt", v), 32'(we_cnt - we0),
                      32'(vecs[v].size ** 2));
                check($sformatf("v%0d_first_cnt", v), 32'(first_cnt - f0),
                      32'(vecs[v].size ** 2));
                check($sformatf("v%0d_last_cnt", v), 32'(last_cnt - l0),
                      32'(vecs[v].size ** 2));
                check($sformatf("v%0d_last_raddr", v), 32'(last_raddr),
                      32'(vecs[v].size ** 2 - 1));
            end
        end

        // Stall for 5 cycles after the third issue of an N=2 job
        start_job(2, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1 stall = 1'b1;
        @(negedge clk);
        check("stall_rd_en", 32'(rd_en), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_hold_a", 32'(a_addr), 32'd1);
        check("stall_hold_b", 32'(b_addr), 32'd3);
        repeat (5) @(posedge clk);
        #1 stall = 1'b0;
        wait_done("stall", t0, 16);

        // Asynchronous reset in ISSUE cycle 4
        d0 = done_cnt;
        start_job(2, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_mac", 32'({mac_valid, mac_first, mac_last}), 32'd0);
        check("abort_r_we", 32'(r_we), 32'd0);
        check("abort_addr", 32'({a_addr, b_addr, r_addr}), 32'd0);
        check("abort_cycles", cycles, 32'd0);
        issue_q.delete();
        raddr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        start_job(2, 1'b1, t0);
        wait_done("after_abort", t0, 11);

        // start while busy and in the done cycle must both be ignored
        d0 = done_cnt; rd0 = rd_cnt;
        start_job(2, 1'b1, t0);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; size = 8'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1; size = 8'd2;
        @(negedge clk);
        check("ign_done_at_11", 32'(done), 32'd1);
        check("ign_done_cycle", 32'(cyc - t0), 32'd11);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("ign_idle", 32'(busy), 32'd0);
        check("ign_one_done", 32'(done_cnt - d0), 32'd1);
        check("ign_rd_cnt", 32'(rd_cnt - rd0), 32'd8);
        check("ign_issue_q_empty", 32'(issue_q.size()), 32'd0);
`ifdef PERF_CNT_EN
        check("perf_cycles", cycles, 32'd10);
`else
        check("perf_cycles_off", cycles, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
